// File: rtl/stump_alu_pipe_if.sv
// stump_alu_pipe_if: request/result handshake bundle between a producer and the ALU pipe
interface stump_alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic [2:0]       func;
    logic             c_in;
    logic             csh;
    logic             flag_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags_out;
    logic [3:0]       cc;

    modport master (
        output in_valid, operand_A, operand_B, func, c_in, csh, flag_en, out_ready,
        input  in_ready, out_valid, result, flags_out, cc
    );

    modport slave (
        input  in_valid, operand_A, operand_B, func, c_in, csh, flag_en, out_ready,
        output in_ready, out_valid, result, flags_out, cc
    );
endinterface

// File: rtl/stump_alu_pipe.sv
// stump_alu_pipe: single-stage Stump ALU with registered result, sticky flags
// and an optional iterative shift-add multiplier on func 6.
module stump_alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1
) (
    input logic            clk,
    input logic            rst_n,
    stump_alu_pipe_if.slave bus
);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           r_state;
    logic [SW-1:0]    r_step;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             r_flag_en;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [3:0]       r_cc;

    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_bop;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_v;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_alu;
    logic [3:0]       w_alu_flags;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_done;
    logic             w_load;
    logic [WIDTH-1:0] w_new_result;
    logic [3:0]       w_new_flags;
    logic             w_new_fe;

    assign bus.in_ready  = (r_state == IDLE) & (~r_valid | bus.out_ready);
    assign bus.out_valid = r_valid;
    assign bus.result    = r_result;
    assign bus.flags_out = r_flags;
    assign bus.cc        = r_cc;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_is_mul = MUL_EN && (bus.func == 3'd6);

    // SUB/SBC feed ~B into the adder; carry-in is 0/c_in/1/c_in for ADD/ADC/SUB/SBC
    assign w_bop = bus.func[1] ? ~bus.operand_B : bus.operand_B;
    assign w_cin = bus.func[0] ? bus.c_in : bus.func[1];
    assign {w_cout, w_sum} = {1'b0, bus.operand_A} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    assign w_v = (bus.operand_A[WIDTH-1] == w_bop[WIDTH-1]) & (w_sum[WIDTH-1] != bus.operand_A[WIDTH-1]);

    assign w_logic = (bus.func == 3'd4) ? (bus.operand_A & bus.operand_B) :
                     (bus.func == 3'd5) ? (bus.operand_A | bus.operand_B) : bus.operand_A;
    assign w_alu = bus.func[2] ? w_logic : w_sum;
    assign w_alu_flags = {w_alu[WIDTH-1], w_alu == '0, bus.func[2] ? 1'b0 : w_v,
                          bus.func[2] ? bus.csh : w_cout};

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_state == MUL) && (r_step == LAST_STEP);

    assign w_load       = w_mul_done | (w_accept & ~w_is_mul);
    assign w_new_result = w_mul_done ? w_acc_next : w_alu;
    assign w_new_flags  = w_mul_done ? {w_acc_next[WIDTH-1], w_acc_next == '0, 2'b00} : w_alu_flags;
    assign w_new_fe     = w_mul_done ? r_flag_en : bus.flag_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_flag_en <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_cc      <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_accept && w_is_mul) begin
                    r_state   <= MUL;
                    r_step    <= '0;
                    r_mcand   <= bus.operand_A;
                    r_mplier  <= bus.operand_B;
                    r_acc     <= '0;
                    r_flag_en <= bus.flag_en;
                end
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_step   <= r_step + 1'b1;
                if (w_mul_done)
                    r_state <= IDLE;
            end
            if (w_load) begin
                r_result <= w_new_result;
                r_flags  <= w_new_flags;
                if (w_new_fe)
                    r_cc <= w_new_flags;
            end
            r_valid <= w_load | (r_valid & ~bus.out_ready);
        end
    end
endmodule

// File: tb/tb_stump_alu_pipe.sv
// tb_stump_alu_pipe: directed literal checks plus random traffic compared every
// cycle against a transaction-level model of the ALU pipe.
module tb_stump_alu_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stump_alu_pipe_if #(.WIDTH(W)) bus ();
    stump_alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // returns {N,Z,V,C,result} computed from plain integer arithmetic
    function automatic logic [W+3:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] f, input logic ci, input logic cs);
        logic [W-1:0] r, bo;
        logic v, c;
        longint s, ss;
        int cin;
        if (f == 3'd6) begin
            r = W'(longint'(a) * longint'(b));
            v = 1'b0;
            c = 1'b0;
        end else if (f >= 3'd4) begin
            r = (f == 3'd4) ? (a & b) : (f == 3'd5) ? (a | b) : a;
            v = 1'b0;
            c = cs;
        end else begin
            bo  = f[1] ? ~b : b;
            cin = (f == 3'd0) ? 0 : (f == 3'd2) ? 1 : int'(ci);
            s   = longint'(a) + longint'(bo) + cin;
            r   = W'(s);
            c   = s >= (longint'(1) << W);
            ss  = longint'($signed(a)) + longint'($signed(bo)) + cin;
            v   = (ss > longint'(2 ** (W - 1) - 1)) || (ss < -longint'(2 ** (W - 1)));
        end
        return {r[W-1], r == '0, v, c, r};
    endfunction

    logic           m_valid, m_rdy, m_acc, m_pend_fe;
    logic [W-1:0]   m_result;
    logic [3:0]     m_flags, m_cc;
    logic [W+3:0]   m_op, m_pend;
    int             m_cnt;

    initial begin
        m_valid = 0; m_result = '0; m_flags = '0; m_cc = '0; m_cnt = 0; m_pend = '0; m_pend_fe = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_flags", bus.flags_out, 0);
            chk("rst_cc", bus.cc, 0);
            m_valid = 0; m_result = '0; m_flags = '0; m_cc = '0; m_cnt = 0;
        end else begin
            m_rdy = (m_cnt == 0) && (!m_valid || bus.out_ready);
            chk("in_ready", bus.in_ready, m_rdy);
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("result", bus.result, m_result);
                chk("flags_out", bus.flags_out, m_flags);
            end
            chk("cc", bus.cc, m_cc);
            m_acc = bus.in_valid && m_rdy;
            m_valid = m_valid && !bus.out_ready;
            if (m_cnt == 1) begin
                m_result = m_pend[W-1:0];
                m_flags  = m_pend[W+3:W];
                m_valid  = 1;
                if (m_pend_fe) m_cc = m_flags;
            end else if (m_acc && bus.func != 3'd6) begin
                m_op     = ref_op(bus.operand_A, bus.operand_B, bus.func, bus.c_in, bus.csh);
                m_result = m_op[W-1:0];
                m_flags  = m_op[W+3:W];
                m_valid  = 1;
                if (bus.flag_en) m_cc = m_flags;
            end
            if (m_cnt > 0) m_cnt--;
            if (m_acc && bus.func == 3'd6) begin
                m_pend    = ref_op(bus.operand_A, bus.operand_B, bus.func, bus.c_in, bus.csh);
                m_pend_fe = bus.flag_en;
                m_cnt     = W;
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                         input logic ci, input logic cs, input logic fe);
        logic ok = 0;
        bus.operand_A = a; bus.operand_B = b; bus.func = f;
        bus.c_in = ci; bus.csh = cs; bus.flag_en = fe; bus.in_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 0;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                      input logic ci, input logic cs, input logic fe,
                      input logic [W-1:0] er, input logic [3:0] ef, input logic [3:0] ecc, input int elat);
        int lat = 0;
        logic seen = 0;
        drive(a, b, f, ci, cs, fe);
        for (int i = 0; i < W + 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
            else lat++;
        end
        chk("lit_latency", lat, elat);
        chk("lit_result", bus.result, er);
        chk("lit_flags", bus.flags_out, ef);
        chk("lit_cc", bus.cc, ecc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idle_valid;
        bus.in_valid = 0; bus.operand_A = '0; bus.operand_B = '0; bus.func = '0;
        bus.c_in = 0; bus.csh = 0; bus.flag_en = 0; bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("ready_after_reset", bus.in_ready, 1);
        chk("valid_after_reset", bus.out_valid, 0);

        op(16'h4000, 16'h3FFF, 3'd0, 0, 0, 1, 16'h7FFF, 4'b0000, 4'b0000, 0);
        op(16'h5000, 16'h5000, 3'd0, 0, 0, 1, 16'hA000, 4'b1010, 4'b1010, 0);
        op(16'h4000, 16'hBFFF, 3'd2, 0, 0, 1, 16'h8001, 4'b1010, 4'b1010, 0);
        op(16'h4000, 16'h4000, 3'd3, 0, 0, 1, 16'hFFFF, 4'b1000, 4'b1000, 0);
        op(16'hC000, 16'h9000, 3'd4, 0, 1, 0, 16'h8000, 4'b1001, 4'b1000, 0);
        op(16'hC000, 16'h9000, 3'd4, 0, 1, 1, 16'h8000, 4'b1001, 4'b1001, 0);
        op(16'hFFFF, 16'h0000, 3'd1, 1, 0, 1, 16'h0000, 4'b0101, 4'b0101, 0);
        op(16'h00F0, 16'h0F00, 3'd5, 0, 0, 1, 16'h0FF0, 4'b0000, 4'b0000, 0);
        op(16'h8000, 16'h1234, 3'd7, 0, 1, 1, 16'h8000, 4'b1001, 4'b1001, 0);
        op(16'h0100, 16'h0100, 3'd6, 0, 0, 1, 16'h0000, 4'b0100, 4'b0100, W);
        op(16'h00FF, 16'h0003, 3'd6, 0, 0, 1, 16'h02FD, 4'b0000, 4'b0000, W);

        // backpressure: first result held while a second request waits
        bus.out_ready = 0;
        drive(16'h1234, 16'h0001, 3'd0, 0, 0, 1);
        bus.operand_A = 16'h0002; bus.operand_B = 16'h0003; bus.func = 3'd0; bus.in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result_held", bus.result, 16'h1235);
            chk("bp_in_ready_low", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1;
        @(negedge clk);
        chk("bp_ready_on_consume", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 0;
        @(negedge clk);
        chk("bp_second_result", bus.result, 16'h0005);
        chk("bp_second_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;

        // reset in the middle of a multiply
        op(16'h4000, 16'hBFFF, 3'd2, 0, 0, 1, 16'h8001, 4'b1010, 4'b1010, 0);
        drive(16'h0003, 16'h0005, 3'd6, 0, 0, 1);
        repeat (7) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_cc", bus.cc, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        idle_valid = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) idle_valid++;
        end
        chk("abort_no_result", idle_valid, 0);
        @(posedge clk);
        #1;
        op(16'h7FFF, 16'h0001, 3'd0, 0, 0, 1, 16'h8000, 4'b1010, 4'b1010, 0);

        // random traffic; operands keep changing during multiplies
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] edge_v [4];
            edge_v[0] = '0; edge_v[1] = '1; edge_v[2] = 16'h8000; edge_v[3] = 16'h7FFF;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.operand_A = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
            bus.operand_B = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
            bus.func      = 3'($urandom_range(0, 7));
            bus.c_in      = 1'($urandom);
            bus.csh       = 1'($urandom);
            bus.flag_en   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        repeat (W + 4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
